status_value_drain: RTL and testbench

Downstream consumer stage for the status value vector. It pulls the oldest entry whenever one is valid and it has space. Pulled entries go into a 2-entry output buffer with a valid/ready handshake. It can optionally discard entries that match a programmable value, counts forwarded and dropped entries, and flags a consumer that stalls for too long.

---
 rtl/status_value_drain.sv | 124 ++++++++++++
 tb/tb_status_value_drain.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/status_value_drain.sv
// Consumer stage for the status value vector: pulls head entries into a
// 2-entry output FIFO, optionally filters a value, counts traffic and flags stalls.
module status_value_drain #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned STALL_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic [WIDTH-1:0] sv_value_i,
  input  logic             sv_valid_i,
  output logic             sv_pull_o,
  output logic [WIDTH-1:0] out_value_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             flush_i,
  input  logic             drop_en_i,
  input  logic [WIDTH-1:0] drop_value_i,
  output logic [CNT_W-1:0] fwd_count_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic             stall_o
);

  localparam int unsigned SW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] fwd_q, fwd_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
  logic             stall_q, stall_d;

  logic match, full, pop, push, stalling;

  // Pull ignores out_ready_i so no combinational path runs from consumer to vector;
  // rsn_i gating keeps the pull low while reset is held.
  assign match       = drop_en_i & (sv_value_i == drop_value_i);
  assign full        = (occ_q == 2'd2);
  assign sv_pull_o   = rsn_i & sv_valid_i & ~flush_i & (match | ~full);
  assign out_valid_o = (occ_q != 2'd0);
  assign out_value_o = mem_q[rd_ptr_q];
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign push        = sv_pull_o & ~match;
  assign stalling    = out_valid_o & ~out_ready_i;

  assign fwd_count_o  = fwd_q;
  assign drop_count_o = drop_q;
  assign stall_o      = stall_q;

  always_comb begin
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    fwd_d       = fwd_q;
    drop_d      = drop_q;
    stall_cnt_d = stall_cnt_q;
    stall_d     = stall_q;

    if (flush_i) begin
      rd_ptr_d    = 1'b0;
      wr_ptr_d    = 1'b0;
      occ_d       = 2'd0;
      stall_cnt_d = '0;
      stall_d     = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = sv_value_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};

      if (pop && (fwd_q != '1)) begin
        fwd_d = fwd_q + CNT_W'(1);
      end

      if (stalling) begin
        if (stall_cnt_q != STALL_MAX) begin
          stall_cnt_d = stall_cnt_q + SW'(1);
        end
      end else begin
        stall_cnt_d = '0;
      end
      stall_d = stall_q | (stall_cnt_d == STALL_MAX);
    end

    // Filtered entries are counted even on a flush-free full buffer; flush blocks the pull itself.
    if (sv_pull_o && match && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      fwd_q       <= '0;
      drop_q      <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      fwd_q       <= fwd_d;
      drop_q      <= drop_d;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_status_value_drain.sv
// Randomized and directed bench for status_value_drain against a queue-based model.
module tb_status_value_drain;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned STALL = 16;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rsn_i;
  logic [WIDTH-1:0] sv_value_i;
  logic             sv_valid_i;
  logic             sv_pull_o;
  logic [WIDTH-1:0] out_value_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             flush_i;
  logic             drop_en_i;
  logic [WIDTH-1:0] drop_value_i;
  logic [CNT_W-1:0] fwd_count_o;
  logic [CNT_W-1:0] drop_count_o;
  logic             stall_o;

  status_value_drain #(.WIDTH(WIDTH), .CNT_W(CNT_W), .STALL_CYCLES(STALL)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .sv_value_i(sv_value_i), .sv_valid_i(sv_valid_i), .sv_pull_o(sv_pull_o),
    .out_value_o(out_value_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .flush_i(flush_i), .drop_en_i(drop_en_i), .drop_value_i(drop_value_i),
    .fwd_count_o(fwd_count_o), .drop_count_o(drop_count_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: source vector, output buffer, counters, stall run length.
  int src[$];
  int buf_q[$];
  int m_fwd, m_drop, m_run;
  bit m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    buf_q.delete();
    m_fwd = 0; m_drop = 0; m_run = 0; m_stall = 0;
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks the pull, then outputs after the edge.
  task automatic step(input bit rdy, input bit fl, input bit den, input int dval);
    bit valid, match, pull;
    int head;
    valid = (src.size() > 0);
    head  = valid ? src[0] : 0;
    sv_valid_i   = valid;
    sv_value_i   = WIDTH'(head);
    out_ready_i  = rdy;
    flush_i      = fl;
    drop_en_i    = den;
    drop_value_i = WIDTH'(dval);
    #1;
    match = den && valid && (head == dval);
    pull  = valid && !fl && (match || buf_q.size() != 2);
    check("sv_pull", 32'(sv_pull_o), 32'(pull));

    if (fl) begin
      buf_q.delete();
      m_stall = 0;
      m_run   = 0;
    end else begin
      if (buf_q.size() > 0 && !rdy) m_run = (m_run < STALL) ? m_run + 1 : STALL;
      else m_run = 0;
      if (m_run == STALL) m_stall = 1;
      if (buf_q.size() > 0 && rdy) begin
        void'(buf_q.pop_front());
        if (m_fwd < CMAX) m_fwd++;
      end
    end
    if (pull) begin
      void'(src.pop_front());
      if (match) begin
        if (m_drop < CMAX) m_drop++;
      end else begin
        buf_q.push_back(head);
      end
    end

    @(posedge clk_i);
    #1;
    check("out_valid", 32'(out_valid_o), 32'(buf_q.size() > 0));
    if (buf_q.size() > 0) check("out_value", 32'(out_value_o), 32'(buf_q[0]));
    check("fwd_count", 32'(fwd_count_o), 32'(m_fwd));
    check("drop_count", 32'(drop_count_o), 32'(m_drop));
    check("stall", 32'(stall_o), 32'(m_stall));
  endtask

  initial begin
    rsn_i = 1'b0; sv_value_i = '0; sv_valid_i = 1'b0; out_ready_i = 1'b0;
    flush_i = 1'b0; drop_en_i = 1'b0; drop_value_i = '0;
    model_reset();
    #12;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_value", 32'(out_value_o), 32'd0);
    check("rst_pull", 32'(sv_pull_o), 32'd0);
    check("rst_fwd", 32'(fwd_count_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    rsn_i = 1'b1;
    @(posedge clk_i); #1;

    // Three values streamed straight through.
    src = '{1, 2, 3};
    repeat (5) step(1, 0, 0, 0);
    check("fwd_after_3", 32'(fwd_count_o), 32'd3);

    // Back-pressure with five queued: two pulls then hold, then drain.
    src = '{7, 8, 9, 10, 11};
    repeat (4) step(0, 0, 0, 0);
    check("src_left_after_bp", 32'(src.size()), 32'd3);
    repeat (6) step(1, 0, 0, 0);
    check("fwd_after_5", 32'(fwd_count_o), 32'd8);

    // Filter value 5 while buffer is full.
    src = '{12, 13, 4, 5, 6, 5};
    repeat (3) step(0, 0, 1, 5);
    repeat (8) step(1, 0, 1, 5);
    check("drop_after_filter", 32'(drop_count_o), 32'd2);

    // Stall watchdog, stickiness, and flush with a simultaneous handshake.
    src = '{3};
    repeat (20) step(0, 0, 0, 0);
    src = '{1, 2};
    repeat (2) step(1, 0, 0, 0);
    check("stall_sticky", 32'(stall_o), 32'd1);
    step(1, 1, 0, 0);
    check("stall_flushed", 32'(stall_o), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) src.push_back(int'($urandom_range(0, 15)));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset with a full buffer.
    src = '{1, 2, 3, 4, 5};
    repeat (3) step(0, 0, 0, 0);
    rsn_i = 1'b0;
    #1;
    check("async_valid", 32'(out_valid_o), 32'd0);
    check("async_value", 32'(out_value_o), 32'd0);
    check("async_pull", 32'(sv_pull_o), 32'd0);
    check("async_fwd", 32'(fwd_count_o), 32'd0);
    check("async_drop", 32'(drop_count_o), 32'd0);
    #2;
    rsn_i = 1'b1;
    model_reset();
    repeat (6) step(1, 0, 0, 0);

    // Forwarded-count saturation.
    for (int i = 0; i < 262; i++) src.push_back(i % 16);
    repeat (266) step(1, 0, 0, 0);
    check("fwd_saturated", 32'(fwd_count_o), 32'(CMAX));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
